mux_pipe_nch: RTL and testbench

//   Registered N-channel, NBITS-wide selector with a valid/ready handshake, one-cycle latency,

---
 rtl/mux_pipe_nch.sv | 120 ++++++++++++
 tb/tb_mux_pipe_nch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_nch.sv
// Registered N-channel selector with valid/ready handshake, flush and a wrapping transfer counter.
// Optional build macro MUX_PIPE_SKID_EN adds a one-entry skid buffer and decouples in_ready from out_ready.
module mux_pipe_nch #(
  parameter int NBITS = 7,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*NBITS-1:0] in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [NBITS-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  output logic [CNTW-1:0]      xfer_cnt
);

  logic [NBITS-1:0] pick_data;
  logic             pick_err;
  logic             accept;
  logic             xfer;

  logic [NBITS-1:0] data_reg;
  logic [SELW-1:0]  sel_reg;
  logic             valid_reg;
  logic             err_reg;
  logic [CNTW-1:0]  cnt_reg;

  // Out-of-range selects yield zero data; the error flag is raised separately.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) pick_data = in_data[k*NBITS +: NBITS];
    end
    pick_err = ({1'b0, sel} >= (SELW+1)'(NCH));
  end

  assign xfer   = valid_reg & out_ready;
  assign accept = in_valid & in_ready;

`ifdef MUX_PIPE_SKID_EN
  logic [NBITS-1:0] skid_data_reg;
  logic [SELW-1:0]  skid_sel_reg;
  logic             skid_valid_reg;

  assign in_ready = !flush && !skid_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg       <= '0;
      sel_reg        <= '0;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
      skid_data_reg  <= '0;
      skid_sel_reg   <= '0;
      skid_valid_reg <= 1'b0;
    end else begin
      err_reg <= accept & pick_err;
      if (xfer) cnt_reg <= cnt_reg + CNTW'(1);
      if (flush) begin
        valid_reg      <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (accept && (!valid_reg || xfer)) begin
        // Skid is necessarily empty here, so the new word goes straight to the output.
        data_reg  <= pick_data;
        sel_reg   <= sel;
        valid_reg <= 1'b1;
      end else if (accept) begin
        skid_data_reg  <= pick_data;
        skid_sel_reg   <= sel;
        skid_valid_reg <= 1'b1;
      end else if (xfer && skid_valid_reg) begin
        data_reg       <= skid_data_reg;
        sel_reg        <= skid_sel_reg;
        skid_valid_reg <= 1'b0;
      end else if (xfer) begin
        valid_reg <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !flush && (!valid_reg || out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      err_reg <= accept & pick_err;
      if (xfer) cnt_reg <= cnt_reg + CNTW'(1);
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (accept) begin
        data_reg  <= pick_data;
        sel_reg   <= sel;
        valid_reg <= 1'b1;
      end else if (xfer) begin
        valid_reg <= 1'b0;
      end
    end
  end
`endif

  assign out_data  = data_reg;
  assign out_sel   = sel_reg;
  assign out_valid = valid_reg;
  assign sel_err   = err_reg;
  assign xfer_cnt  = cnt_reg;

endmodule

// File: tb/tb_mux_pipe_nch.sv
// Bench for mux_pipe_nch: a 4-channel/8-bit-counter instance and a 3-channel/4-bit-counter instance
// share one stimulus stream; a queue-style model checks both every cycle, plus literal spot checks.
module tb_mux_pipe_nch;

`ifdef MUX_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       flush = 1'b0;

  logic [27:0] in_data_a = {7'h13, 7'h12, 7'h11, 7'h10};
  logic [20:0] in_data_b = {7'h12, 7'h11, 7'h10};

  logic       in_ready_a, out_valid_a, sel_err_a;
  logic [6:0] out_data_a;
  logic [1:0] out_sel_a;
  logic [7:0] xfer_cnt_a;
  logic       in_ready_b, out_valid_b, sel_err_b;
  logic [6:0] out_data_b;
  logic [1:0] out_sel_b;
  logic [3:0] xfer_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_pipe_nch #(.NBITS(7), .NCH(4), .SELW(2), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_a), .flush(flush), .out_data(out_data_a), .out_sel(out_sel_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .sel_err(sel_err_a), .xfer_cnt(xfer_cnt_a)
  );

  mux_pipe_nch #(.NBITS(7), .NCH(3), .SELW(2), .CNTW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_b), .flush(flush), .out_data(out_data_b), .out_sel(out_sel_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .sel_err(sel_err_b), .xfer_cnt(xfer_cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance, a FIFO of held words (capacity 1 without skid, 2 with skid).
  int         nch_m[2] = '{4, 3};
  int         mod_m[2] = '{256, 16};
  int         mn[2];
  logic [6:0] md[2][2];
  logic [1:0] ms[2][2];
  int         mcnt[2];
  bit         merr[2];
  bit         mzero[2];
  bit         live = 1'b0;

  function automatic bit exp_ready(int m);
    if (flush) return 1'b0;
    if (SKID) return mn[m] < 2;
    return (mn[m] == 0) || out_ready;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        mn[m] = 0; mcnt[m] = 0; merr[m] = 1'b0; mzero[m] = 1'b1;
      end else begin
        bit acc, xf;
        acc = in_valid && exp_ready(m);
        xf  = (mn[m] > 0) && out_ready;
        if (xf) mcnt[m] = (mcnt[m] + 1) % mod_m[m];
        if (flush) begin
          mn[m] = 0; merr[m] = 1'b0;
        end else begin
          if (xf) begin
            md[m][0] = md[m][1]; ms[m][0] = ms[m][1]; mn[m]--;
          end
          if (acc) begin
            md[m][mn[m]] = (int'(sel) < nch_m[m]) ? 7'(16 + int'(sel)) : 7'd0;
            ms[m][mn[m]] = sel;
            mn[m]++;
            mzero[m] = 1'b0;
          end
          merr[m] = acc && (int'(sel) >= nch_m[m]);
        end
      end
    end
    live = 1'b1;
  end

  task automatic cmp(input int m, input logic v, input logic r, input logic e,
                     input logic [6:0] d, input logic [1:0] s, input int x);
    string p;
    p = (m == 0) ? "a" : "b";
    chk({p, ".out_valid"}, 32'(v), 32'(mn[m] > 0));
    chk({p, ".in_ready"}, 32'(r), 32'(exp_ready(m)));
    chk({p, ".sel_err"}, 32'(e), 32'(merr[m]));
    chk({p, ".xfer_cnt"}, 32'(x), 32'(mcnt[m]));
    if (mn[m] > 0 || mzero[m]) begin
      chk({p, ".out_data"}, 32'(d), mzero[m] ? 32'd0 : 32'(md[m][0]));
      chk({p, ".out_sel"}, 32'(s), mzero[m] ? 32'd0 : 32'(ms[m][0]));
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp(0, out_valid_a, in_ready_a, sel_err_a, out_data_a, out_sel_a, int'(xfer_cnt_a));
      cmp(1, out_valid_b, in_ready_b, sel_err_b, out_data_b, out_sel_b, int'(xfer_cnt_b));
    end
  end

  task automatic set_in(input bit v, input logic [1:0] s, input bit r, input bit f);
    in_valid = v; sel = s; out_ready = r; flush = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit v, input logic [1:0] s, input bit r, input bit f);
    set_in(v, s, r, f);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 2'd0, 1'b1, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset.out_valid", 32'(out_valid_a), 32'd0);
    chk("reset.xfer_cnt", 32'(xfer_cnt_a), 32'd0);

    // Single word on channel 2.
    cyc(1'b1, 2'd2, 1'b1, 1'b0);
    chk("t1.out_valid", 32'(out_valid_a), 32'd1);
    chk("t1.out_data", 32'(out_data_a), 32'h12);
    chk("t1.out_sel", 32'(out_sel_a), 32'd2);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t1.xfer_cnt", 32'(xfer_cnt_a), 32'd1);

    // Back-to-back stream.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'(i), 1'b1, 1'b0);
      #1;
      chk("t2.in_ready", 32'(in_ready_a), 32'd1);
      step();
      chk("t2.out_data", 32'(out_data_a), 32'(8'h10 + i));
    end
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t2.xfer_cnt", 32'(xfer_cnt_a), 32'd4);

    // Stall with a held word.
    do_reset();
    cyc(1'b1, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'd2, 1'b0, 1'b0);
      #1;
      chk("t3.in_ready", 32'(in_ready_a), 32'(SKID && i == 0));
      step();
      chk("t3.out_data", 32'(out_data_a), 32'h11);
      chk("t3.out_valid", 32'(out_valid_a), 32'd1);
    end
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t3.release_valid", 32'(out_valid_a), 32'(SKID));
    if (out_valid_a) chk("t3.skid_data", 32'(out_data_a), 32'h12);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t3.xfer_cnt", 32'(xfer_cnt_a), SKID ? 32'd2 : 32'd1);

    // Out-of-range select on the 3-channel instance.
    do_reset();
    cyc(1'b1, 2'd3, 1'b1, 1'b0);
    chk("t4.out_data", 32'(out_data_b), 32'd0);
    chk("t4.out_sel", 32'(out_sel_b), 32'd3);
    chk("t4.sel_err", 32'(sel_err_b), 32'd1);
    chk("t4.a_data", 32'(out_data_a), 32'h13);
    chk("t4.a_sel_err", 32'(sel_err_a), 32'd0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t4.sel_err_drop", 32'(sel_err_b), 32'd0);

    // Flush while full and stalled, then flush with a transfer, then reset mid-stream.
    do_reset();
    cyc(1'b1, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    set_in(1'b1, 2'd2, 1'b0, 1'b1);
    #1;
    chk("t5.flush_ready", 32'(in_ready_a), 32'd0);
    step();
    chk("t5.flush_valid", 32'(out_valid_a), 32'd0);
    chk("t5.flush_cnt", 32'(xfer_cnt_a), 32'd0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0);
    chk("t5.after_data", 32'(out_data_a), 32'h13);
    cyc(1'b0, 2'd0, 1'b1, 1'b1);
    chk("t5.flush_xfer_cnt", 32'(xfer_cnt_a), 32'd1);
    chk("t5.flush_xfer_valid", 32'(out_valid_a), 32'd0);
    cyc(1'b1, 2'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 2'd2, 1'b1, 1'b0);
    chk("t5.rst_valid", 32'(out_valid_a), 32'd0);
    chk("t5.rst_data", 32'(out_data_a), 32'd0);
    chk("t5.rst_sel", 32'(out_sel_a), 32'd0);
    chk("t5.rst_cnt", 32'(xfer_cnt_a), 32'd0);
    chk("t5.rst_b_cnt", 32'(xfer_cnt_b), 32'd0);
    chk("t5.rst_b_err", 32'(sel_err_b), 32'd0);
    rst_n = 1'b1;

    // Counter wrap on the 4-bit instance.
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      if (i == 16) chk("t6.cnt15", 32'(xfer_cnt_b), 32'd15);
    end
    chk("t6.cnt0", 32'(xfer_cnt_b), 32'd0);
    chk("t6.a_cnt16", 32'(xfer_cnt_a), 32'd16);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t6.cnt1", 32'(xfer_cnt_b), 32'd1);
    chk("t6.a_cnt17", 32'(xfer_cnt_a), 32'd17);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
